// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, fetched word held until decode accepts it.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in ST_ERR instead of clearing bits [1:0].
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_err_o
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {ST_RESET, ST_REQ, ST_WAIT, ST_HOLD, ST_ERR} state_t;
`else
  typedef enum logic [1:0] {ST_RESET, ST_REQ, ST_WAIT, ST_HOLD} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] npc, npc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] instr_word, instr_word_nxt;
  logic [31:0] instr_addr, instr_addr_nxt;
  logic        kill, kill_nxt;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |redirect_pc_i[1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= ST_RESET;
      npc        <= RESET_PC;
      req_addr   <= '0;
      kill       <= 1'b0;
      instr_word <= '0;
      instr_addr <= '0;
    end else begin
      state      <= state_nxt;
      npc        <= npc_nxt;
      req_addr   <= req_addr_nxt;
      kill       <= kill_nxt;
      instr_word <= instr_word_nxt;
      instr_addr <= instr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    npc_nxt        = npc;
    req_addr_nxt   = req_addr;
    kill_nxt       = kill;
    instr_word_nxt = instr_word;
    instr_addr_nxt = instr_addr;
    case (state)
      ST_RESET: begin
        state_nxt    = ST_REQ;
        req_addr_nxt = npc;
      end
      ST_REQ: begin
        // A killed request must not advance npc; it already holds the redirect target.
        if (mem_gnt_i) begin
          state_nxt = ST_WAIT;
          if (!kill) npc_nxt = req_addr + 32'd4;
        end
        if (redirect_i) begin
          npc_nxt  = redirect_tgt;
          kill_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (kill || redirect_i) begin
            kill_nxt     = 1'b0;
            req_addr_nxt = redirect_i ? redirect_tgt : npc;
            state_nxt    = ST_REQ;
          end else begin
            instr_word_nxt = mem_rdata_i;
            instr_addr_nxt = req_addr;
            state_nxt      = ST_HOLD;
          end
        end else if (redirect_i) begin
          kill_nxt = 1'b1;
        end
        if (redirect_i) npc_nxt = redirect_tgt;
      end
      ST_HOLD: begin
        if (redirect_i) begin
          npc_nxt      = redirect_tgt;
          req_addr_nxt = redirect_tgt;
          state_nxt    = ST_REQ;
        end else if (instr_ready_i) begin
          req_addr_nxt = npc;
          state_nxt    = ST_REQ;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_ERR: begin
        // A response still in flight is drained through ST_WAIT with kill set.
        if (mem_rvalid_i) kill_nxt = 1'b0;
        if (redirect_i && !misaligned) begin
          npc_nxt = redirect_tgt;
          if (kill && !mem_rvalid_i) begin
            state_nxt = ST_WAIT;
          end else begin
            req_addr_nxt = redirect_tgt;
            state_nxt    = ST_REQ;
          end
        end
      end
`endif
      default: state_nxt = ST_RESET;
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (redirect_i && misaligned && state != ST_RESET && state != ST_ERR) begin
      state_nxt = ST_ERR;
      kill_nxt  = (state == ST_REQ && mem_gnt_i) || (state == ST_WAIT && !mem_rvalid_i);
    end
`endif
  end

  always_comb begin
    mem_req_o     = 1'b0;
    instr_valid_o = 1'b0;
    fetch_err_o   = 1'b0;
    case (state)
      ST_REQ:  mem_req_o     = 1'b1;
      ST_HOLD: instr_valid_o = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      ST_ERR:  fetch_err_o   = 1'b1;
`endif
      default: ;
    endcase
  end

  assign mem_addr_o   = req_addr;
  assign instr_data_o = instr_word;
  assign instr_pc_o   = instr_addr;

endmodule
